uart_label_parser: RTL
======================

Name: uart_label_parser

Overview:
- Consumes the byte stream from the UART RX interface (rx_data/rx_valid/rx_ready).
- Assembles 4-byte label frames: SOF, CMD, ARG, CHK.
- Validates each frame and drives label_in of the NIDS classifier, plus a status-request pulse toward the alert/TX path.
- Malformed frames are counted and discarded; the parser then resynchronises on the next SOF.

Parameters:
- SOF_BYTE, 8'hA5, start-of-frame marker.
- NUM_CLASSES, 8, number of legal label values; ARG must be < NUM_CLASSES.
- TIMEOUT_CYCLES, 1_250_000, maximum idle clk cycles between bytes inside a frame (10 ms at 125 MHz). Used only with LABEL_TIMEOUT_EN.
- CMD_LABEL, 8'h4C, 'L': set label.
- CMD_STATUS, 8'h52, 'R': request status.

Ports:
- clk  input  1  system clock (125 MHz).
- rst  input  1  reset, synchronous, active-high.
- rx_data  input  8  byte from UART RX; valid only when rx_valid=1.
- rx_valid  input  1  one-cycle pulse per received byte.
- rx_ready  output  1  pop request to the UART RX FIFO.
- label_out  output  8  last accepted label (drives label_in).
- label_valid  output  1  one-cycle pulse when label_out is updated.
- status_req  output  1  one-cycle pulse on an accepted 'R' frame.
- err_cnt  output  8  saturating count of rejected frames.
- busy  output  1  high while the parser is mid-frame (state != IDLE).

Behaviour:
- Reset values: rx_ready=0, label_out=0, label_valid=0, status_req=0, err_cnt=0, busy=0, state=IDLE.
- rx_ready is registered. It goes to 1 the first cycle after rst deasserts and stays 1. The parser accepts one byte on every cycle where rx_valid=1, with no backpressure.
- Checksum: CHK = SOF_BYTE ^ CMD ^ ARG (8-bit XOR).
- FSM states: IDLE, GOT_SOF, GOT_CMD, GOT_ARG.
  - IDLE: a byte equal to SOF_BYTE goes to GOT_SOF. Any other byte is dropped silently and is not counted.
  - GOT_SOF: latch CMD and go to GOT_CMD. No validation in this state.
  - GOT_CMD: latch ARG and go to GOT_ARG.
  - GOT_ARG: compare the received byte against the computed CHK, then return to IDLE.
- Frame evaluation, on the CHK byte, in priority order:
  - CHK mismatch -> reject.
  - CMD_LABEL with ARG < NUM_CLASSES -> label_out <= ARG; label_valid=1 on the next cycle.
  - CMD_LABEL with ARG >= NUM_CLASSES -> reject; label_out unchanged.
  - CMD_STATUS (any ARG) -> status_req=1 on the next cycle.
  - Any other CMD -> reject.
- Latency: exactly 1 clk from the rx_valid carrying CHK to the label_valid/status_req pulse.
- Reject: err_cnt <= err_cnt+1, saturating at 8'hFF (no wrap).
- A SOF byte arriving in GOT_SOF/GOT_CMD is treated as data, not as a resync. Resync happens only through reject/timeout back to IDLE.
- Back-to-back frames are supported. A SOF received the cycle after a CHK byte is accepted normally.
- rst mid-frame: immediate return to IDLE. The partial frame is discarded and not counted. label_out clears to 0.
- label_valid and status_req are never asserted in the same cycle.

Optional Feature:
- Macro: LABEL_TIMEOUT_EN.
- Defined:
  - A 21-bit gap counter clears on every rx_valid and on entry to IDLE.
  - It increments while state != IDLE.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE and increments err_cnt (saturating).
  - If rx_valid coincides with the timeout cycle, the byte wins: it is processed normally and the counter clears.
- Not defined: no counter is instantiated, and a partial frame waits indefinitely.

Decomposition:
- Package uart_proto_pkg holds:
  - SOF_BYTE, CMD_LABEL, CMD_STATUS localparams (shared with the future TX alert formatter).
  - The FSM state encoding (2-bit).
  - The checksum function.
- Sub-module uart_gap_timer (counter plus timeout pulse) is instantiated only under LABEL_TIMEOUT_EN.
- Everything else stays flat in uart_label_parser.

Test Plan:
- Send A5 4C 03 EA -> label_valid pulse 1 cycle after the EA byte, label_out=8'h03, err_cnt=0.
- Send A5 52 00 F7 -> status_req single pulse, no label_valid, label_out unchanged.
- Send A5 4C 03 EB (bad CHK), then A5 4C 05 EC -> err_cnt=1 after the first frame; second frame gives label_out=8'h05.
- Send A5 4C 09 E0 (ARG >= NUM_CLASSES, valid CHK) -> err_cnt=1, label_out unchanged. Then send 300 bad frames -> err_cnt saturates at 8'hFF.
- Send garbage 00 FF 13, then A5 4C 01 E8 -> garbage is ignored (err_cnt=0), label_out=8'h01. Assert rst after A5 4C -> busy=0, label_out=0, no pulse.
- With LABEL_TIMEOUT_EN and TIMEOUT_CYCLES=100: send A5 4C, wait 100 cycles -> IDLE, err_cnt=1. Then send A5 4C 02 EB -> label_out=8'h02.

Source files
------------

// File: rtl/uart_proto_pkg.sv
// Shared UART label-protocol constants, parser state encoding and frame checksum.
// Also used by the TX alert formatter.
package uart_proto_pkg;

    localparam logic [7:0] SOF_BYTE   = 8'hA5;
    localparam logic [7:0] CMD_LABEL  = 8'h4C;
    localparam logic [7:0] CMD_STATUS = 8'h52;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT_SOF = 2'd1,
        GOT_CMD = 2'd2,
        GOT_ARG = 2'd3
    } parse_state_t;

    function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] arg);
        return SOF_BYTE ^ cmd ^ arg;
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer for the label parser; compiled only when LABEL_TIMEOUT_EN is defined.
// Pulses timeout while active once TIMEOUT_CYCLES-1 idle cycles have elapsed.
`ifdef LABEL_TIMEOUT_EN
module uart_gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic clear,
    output logic timeout
);

    localparam int unsigned CNT_W = 21;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] gap_cnt;

    assign timeout = active && (gap_cnt == LIMIT);

    // Held at zero whenever the parser is idle, so entry to IDLE always restarts it.
    always_ff @(posedge clk) begin
        if (rst || clear || !active) begin
            gap_cnt <= '0;
        end else if (!timeout) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/uart_label_parser.sv
// Parses 4-byte SOF/CMD/ARG/CHK label frames from the UART RX stream into label and status pulses.
// Define LABEL_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle cycles.
module uart_label_parser
    import uart_proto_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = 8
`ifdef LABEL_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 1_250_000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] label_out,
    output logic       label_valid,
    output logic       status_req,
    output logic [7:0] err_cnt,
    output logic       busy
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    parse_state_t state, state_nxt;
    logic [7:0]   cmd_p0, arg_p0, cmd_nxt, arg_nxt;
    logic [7:0]   label_nxt, err_nxt;
    logic         label_vld_nxt, status_nxt;
    logic         timeout;

`ifdef LABEL_TIMEOUT_EN
    uart_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .active  (state != IDLE),
        .clear   (rx_valid),
        .timeout (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        cmd_nxt       = cmd_p0;
        arg_nxt       = arg_p0;
        label_nxt     = label_out;
        err_nxt       = err_cnt;
        label_vld_nxt = 1'b0;
        status_nxt    = 1'b0;
        // An arriving byte always takes precedence over a coincident timeout.
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == SOF_BYTE) state_nxt = GOT_SOF;
                end
                GOT_SOF: begin
                    cmd_nxt   = rx_data;
                    state_nxt = GOT_CMD;
                end
                GOT_CMD: begin
                    arg_nxt   = rx_data;
                    state_nxt = GOT_ARG;
                end
                GOT_ARG: begin
                    state_nxt = IDLE;
                    if (rx_data != frame_chk(cmd_p0, arg_p0)) begin
                        err_nxt = sat_inc(err_cnt);
                    end else if (cmd_p0 == CMD_LABEL) begin
                        if (32'(arg_p0) < NUM_CLASSES) begin
                            label_nxt     = arg_p0;
                            label_vld_nxt = 1'b1;
                        end else begin
                            err_nxt = sat_inc(err_cnt);
                        end
                    end else if (cmd_p0 == CMD_STATUS) begin
                        status_nxt = 1'b1;
                    end else begin
                        err_nxt = sat_inc(err_cnt);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = IDLE;
            err_nxt   = sat_inc(err_cnt);
        end
    end

    // Output / state register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rx_ready    <= 1'b0;
            label_out   <= 8'h00;
            label_valid <= 1'b0;
            status_req  <= 1'b0;
            err_cnt     <= 8'h00;
        end else begin
            state       <= state_nxt;
            rx_ready    <= 1'b1;
            label_out   <= label_nxt;
            label_valid <= label_vld_nxt;
            status_req  <= status_nxt;
            err_cnt     <= err_nxt;
        end
    end

    // Frame payload capture; only meaningful while mid-frame, so left unreset.
    always_ff @(posedge clk) begin
        cmd_p0 <= cmd_nxt;
        arg_p0 <= arg_nxt;
    end

endmodule
